// File: rtl/nasti_slave_pkg.sv
// rtl/nasti_slave_pkg.sv - NASTI response/burst codes and FSM state types for the RAM responder
package nasti_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic {R_IDLE, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/nasti_channel.sv
// rtl/nasti_channel.sv - NASTI AR/R/AW/W/B channel bundle with the responder-side modport
interface nasti_channel #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1
);
  logic                    ar_valid, ar_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;

  logic                    r_valid, r_ready, r_last;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;

  logic                    aw_valid, aw_ready;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;

  logic                    w_valid, w_ready, w_last;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;

  logic                    b_valid, b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;

  modport slave (
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready,
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready
  );
endinterface

// File: rtl/nasti_ram_burst_addr.sv
// rtl/nasti_ram_burst_addr.sv - per-beat word index, last-beat flag and range check for one burst
module nasti_ram_burst_addr
  import nasti_slave_pkg::*;
#(
  parameter int IDX_WIDTH = 61,
  parameter int WORDS     = 8192
) (
  input  logic [IDX_WIDTH-1:0] start,
  input  logic [7:0]           len,
  input  logic [1:0]           burst,
  input  logic [7:0]           beat,
  output logic [IDX_WIDTH-1:0] cur_idx,
  output logic [IDX_WIDTH-1:0] nxt_idx,
  output logic                 last,
  output logic                 range_err
);
  localparam logic [IDX_WIDTH-1:0] LIMIT = IDX_WIDTH'(WORDS);

  logic                 fixed;
  logic [IDX_WIDTH-1:0] end_idx;

  always_comb begin
    fixed   = (burst == BURST_FIXED);
    cur_idx = fixed ? start : start + IDX_WIDTH'(beat);
    nxt_idx = fixed ? start : start + IDX_WIDTH'({1'b0, beat} + 9'd1);
    end_idx = fixed ? start : start + IDX_WIDTH'(len);
    last    = (beat == len);
    // end_idx < start catches a burst that wraps the index space
    range_err = (start >= LIMIT) || (end_idx >= LIMIT) || (end_idx < start);
  end
endmodule

// File: rtl/nasti_ram_slave.sv
// rtl/nasti_ram_slave.sv - NASTI RAM responder top; NASTI_RAM_SLAVE_PROTO_CHK_EN enables the W-channel protocol checker
module nasti_ram_slave
  import nasti_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_BYTES  = 65536
) (
  input  logic       aclk,
  input  logic       aresetn,
  nasti_channel.slave s,
  output logic       proto_err
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int WORDS = MEM_BYTES / BYTES;
  localparam int IW    = ADDR_WIDTH - SHIFT;
  localparam int MW    = $clog2(WORDS);
  localparam logic [IW-1:0] LIMIT = IW'(WORDS);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  rd_state_t             rd_state;
  logic [IW-1:0]         rd_start_q, rd_start, rd_cur, rd_nxt;
  logic [7:0]            rd_len_q, rd_len, rd_beat, rd_beat_in;
  logic [1:0]            rd_burst_q, rd_burst;
  logic                  rd_last, rd_range_err, rd_err;
  logic                  ar_ready_q, r_valid_q, r_last_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [1:0]            r_resp_q;
  logic [DATA_WIDTH-1:0] r_data_q;

  wr_state_t             wr_state;
  logic [IW-1:0]         wr_start_q, wr_start, wr_cur, wr_nxt;
  logic [7:0]            wr_len_q, wr_len, wr_beat, wr_beat_in;
  logic [1:0]            wr_burst_q, wr_burst;
  logic                  wr_last, wr_range_err, wr_err, wr_err_q;
  logic                  aw_ready_q, w_ready_q, b_valid_q;
  logic [ID_WIDTH-1:0]   b_id_q;
  logic [1:0]            b_resp_q;

  // While idle each address unit looks at the request itself, so err and beat 0 are known at the handshake.
  always_comb begin
    rd_start   = rd_start_q;
    rd_len     = rd_len_q;
    rd_burst   = rd_burst_q;
    rd_beat_in = rd_beat;
    if (rd_state == R_IDLE) begin
      rd_start   = s.ar_addr[ADDR_WIDTH-1:SHIFT];
      rd_len     = s.ar_len;
      rd_burst   = s.ar_burst;
      rd_beat_in = '0;
    end
    rd_err = (s.ar_size != 3'(SHIFT)) || !burst_ok(s.ar_burst) || rd_range_err;
  end

  always_comb begin
    wr_start   = wr_start_q;
    wr_len     = wr_len_q;
    wr_burst   = wr_burst_q;
    wr_beat_in = wr_beat;
    if (wr_state == W_IDLE) begin
      wr_start   = s.aw_addr[ADDR_WIDTH-1:SHIFT];
      wr_len     = s.aw_len;
      wr_burst   = s.aw_burst;
      wr_beat_in = '0;
    end
    wr_err = (s.aw_size != 3'(SHIFT)) || !burst_ok(s.aw_burst) || wr_range_err;
  end

  nasti_ram_burst_addr #(.IDX_WIDTH(IW), .WORDS(WORDS)) u_rd_addr (
    .start(rd_start), .len(rd_len), .burst(rd_burst), .beat(rd_beat_in),
    .cur_idx(rd_cur), .nxt_idx(rd_nxt), .last(rd_last), .range_err(rd_range_err)
  );

  nasti_ram_burst_addr #(.IDX_WIDTH(IW), .WORDS(WORDS)) u_wr_addr (
    .start(wr_start), .len(wr_len), .burst(wr_burst), .beat(wr_beat_in),
    .cur_idx(wr_cur), .nxt_idx(wr_nxt), .last(wr_last), .range_err(wr_range_err)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state   <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      rd_start_q <= '0;
      rd_len_q   <= '0;
      rd_burst_q <= BURST_FIXED;
      rd_beat    <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          ar_ready_q <= 1'b1;
          if (s.ar_valid && ar_ready_q) begin
            rd_state   <= R_BURST;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b1;
            r_last_q   <= rd_last;
            r_id_q     <= s.ar_id;
            r_resp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_data_q   <= (rd_cur < LIMIT) ? mem[rd_cur[MW-1:0]] : '0;
            rd_start_q <= rd_start;
            rd_len_q   <= rd_len;
            rd_burst_q <= rd_burst;
            rd_beat    <= '0;
          end
        end
        R_BURST: begin
          if (s.r_ready) begin
            if (rd_last) begin
              rd_state   <= R_IDLE;
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
            end else begin
              rd_beat  <= rd_beat + 8'd1;
              r_last_q <= (rd_beat + 8'd1 == rd_len_q);
              r_data_q <= (rd_nxt < LIMIT) ? mem[rd_nxt[MW-1:0]] : '0;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state   <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= RESP_OKAY;
      wr_start_q <= '0;
      wr_len_q   <= '0;
      wr_burst_q <= BURST_FIXED;
      wr_err_q   <= 1'b0;
      wr_beat    <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          aw_ready_q <= 1'b1;
          if (s.aw_valid && aw_ready_q) begin
            wr_state   <= W_DATA;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            b_id_q     <= s.aw_id;
            wr_start_q <= wr_start;
            wr_len_q   <= wr_len;
            wr_burst_q <= wr_burst;
            wr_err_q   <= wr_err;
            wr_beat    <= '0;
          end
        end
        W_DATA: begin
          if (s.w_valid) begin
            if (wr_last) begin
              wr_state  <= W_RESP;
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_resp_q  <= wr_err_q ? RESP_SLVERR : RESP_OKAY;
            end else begin
              wr_beat <= wr_beat + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (s.b_ready) begin
            wr_state   <= W_IDLE;
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read-first: the read path samples mem with the same edge that commits a write.
  always_ff @(posedge aclk) begin
    if (aresetn && wr_state == W_DATA && s.w_valid && !wr_err_q) begin
      for (int i = 0; i < BYTES; i++) begin
        if (s.w_strb[i]) mem[wr_cur[MW-1:0]][i*8 +: 8] <= s.w_data[i*8 +: 8];
      end
    end
  end

  assign s.ar_ready = ar_ready_q;
  assign s.r_valid  = r_valid_q;
  assign s.r_last   = r_last_q;
  assign s.r_id     = r_id_q;
  assign s.r_resp   = r_resp_q;
  assign s.r_data   = r_data_q;
  assign s.aw_ready = aw_ready_q;
  assign s.w_ready  = w_ready_q;
  assign s.b_valid  = b_valid_q;
  assign s.b_id     = b_id_q;
  assign s.b_resp   = b_resp_q;

  logic unused_bits;

`ifdef NASTI_RAM_SLAVE_PROTO_CHK_EN
  // Sticky until reset: w_last disagreeing with the beat counter, or W traffic with no burst open.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      proto_err <= 1'b0;
    end else if ((wr_state == W_DATA && s.w_valid && (s.w_last != wr_last)) ||
                 (wr_state == W_IDLE && s.w_valid)) begin
      proto_err <= 1'b1;
    end
  end
  assign unused_bits = ^{s.ar_addr[SHIFT-1:0], s.aw_addr[SHIFT-1:0], wr_nxt};
`else
  assign proto_err   = 1'b0;
  assign unused_bits = ^{s.ar_addr[SHIFT-1:0], s.aw_addr[SHIFT-1:0], wr_nxt, s.w_last};
`endif

endmodule

// File: tb/tb_nasti_ram_slave.sv
// tb/tb_nasti_ram_slave.sv - randomized self-checking bench for nasti_ram_slave against a byte-level RAM model
`timescale 1ns/1ps
module tb_nasti_ram_slave;
  localparam int MEMB  = 65536;
  localparam int WORDS = MEMB / 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic proto_err;

  always #5 aclk = ~aclk;

  nasti_channel #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(2)) bus ();

  nasti_ram_slave #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(2), .MEM_BYTES(MEMB)) dut (
    .aclk(aclk), .aresetn(aresetn), .s(bus), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] ref_mem [WORDS];
  logic [7:0]  ref_kn  [WORDS];
  logic [63:0] wdata [256];
  logic [7:0]  wstrb [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_addr(input logic [63:0] addr, input logic [1:0] burst, input int k);
    return {addr[63:3], 3'b000} + ((burst == 2'd1) ? 64'(k) * 64'd8 : 64'd0);
  endfunction

  function automatic bit burst_err(input logic [63:0] addr, input logic [7:0] len,
                                   input logic [1:0] burst, input logic [2:0] size);
    if (size != 3'd3 || burst > 2'd1) return 1'b1;
    for (int k = 0; k <= int'(len); k++)
      if (beat_addr(addr, burst, k) >= 64'(MEMB)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic fill_rand(input int n, input bit full);
    for (int k = 0; k < n; k++) begin
      wdata[k] = {$urandom(), $urandom()};
      wstrb[k] = full ? 8'hFF : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic wr_burst(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [1:0] id, input int last_beat, input bit gaps);
    bit err;
    int n;
    int w;
    err = burst_err(addr, len, burst, size);
    bus.aw_addr = addr; bus.aw_len = len; bus.aw_burst = burst; bus.aw_size = size; bus.aw_id = id;
    bus.aw_valid = 1'b1;
    n = 0;
    while (!bus.aw_ready && n < 200) begin @(negedge aclk); n++; end
    check("aw_accept", 64'(bus.aw_ready), 64'd1);
    @(negedge aclk);
    bus.aw_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge aclk);
      bus.w_data = wdata[k]; bus.w_strb = wstrb[k]; bus.w_last = (k == last_beat);
      bus.w_valid = 1'b1;
      n = 0;
      while (!bus.w_ready && n < 200) begin @(negedge aclk); n++; end
      check("w_ready", 64'(bus.w_ready), 64'd1);
      @(negedge aclk);
      bus.w_valid = 1'b0;
      bus.w_last = 1'b0;
      if (!err) begin
        w = int'(beat_addr(addr, burst, k) >> 3);
        for (int b = 0; b < 8; b++)
          if (wstrb[k][b]) begin
            ref_mem[w][b*8 +: 8] = wdata[k][b*8 +: 8];
            ref_kn[w][b] = 1'b1;
          end
      end
    end
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge aclk);
    bus.b_ready = 1'b1;
    n = 0;
    while (!bus.b_valid && n < 200) begin @(negedge aclk); n++; end
    check("b_valid", 64'(bus.b_valid), 64'd1);
    check("b_id", 64'(bus.b_id), 64'(id));
    check("b_resp", 64'(bus.b_resp), err ? 64'd2 : 64'd0);
    @(negedge aclk);
    bus.b_ready = 1'b0;
  endtask

  // mode 0: r_ready always high, 1: random, 2: pattern 1,0,0 repeating
  task automatic rd_burst(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [1:0] id, input int mode);
    bit err, stalled, rdy;
    int n, k, cyc;
    logic [63:0] a, held, mask;
    logic [63:0] exp_d [256];
    logic [7:0]  exp_m [256];
    err = burst_err(addr, len, burst, size);
    bus.ar_addr = addr; bus.ar_len = len; bus.ar_burst = burst; bus.ar_size = size; bus.ar_id = id;
    bus.ar_valid = 1'b1;
    n = 0;
    while (!bus.ar_ready && n < 200) begin @(negedge aclk); n++; end
    check("ar_accept", 64'(bus.ar_ready), 64'd1);
    for (int j = 0; j <= int'(len); j++) begin
      a = beat_addr(addr, burst, j);
      if (a >= 64'(MEMB)) begin exp_d[j] = '0; exp_m[j] = 8'hFF; end
      else begin exp_d[j] = ref_mem[int'(a >> 3)]; exp_m[j] = ref_kn[int'(a >> 3)]; end
    end
    @(negedge aclk);
    bus.ar_valid = 1'b0;
    check("r_first", 64'(bus.r_valid), 64'd1);
    k = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (k <= int'(len) && cyc < 2000) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc % 3 == 0);
      endcase
      bus.r_ready = rdy;
      if (stalled) begin
        check("r_hold_valid", 64'(bus.r_valid), 64'd1);
        check("r_hold_data", bus.r_data, held);
      end
      if (bus.r_valid && rdy) begin
        check("r_resp", 64'(bus.r_resp), err ? 64'd2 : 64'd0);
        check("r_last", 64'(bus.r_last), 64'(k == int'(len)));
        check("r_id", 64'(bus.r_id), 64'(id));
        for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{exp_m[k][b]}};
        if (burst <= 2'd1 && mask != 64'd0) check("r_data", bus.r_data & mask, exp_d[k] & mask);
        k++;
      end
      stalled = bus.r_valid && !rdy;
      held = bus.r_data;
      @(negedge aclk);
      cyc++;
    end
    bus.r_ready = 1'b0;
    check("r_beats", 64'(k), 64'(int'(len) + 1));
    check("ar_ready_back", 64'(bus.ar_ready), 64'd1);
    check("r_valid_idle", 64'(bus.r_valid), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    check("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    check("rst_w_ready", 64'(bus.w_ready), 64'd0);
    check("rst_r_valid", 64'(bus.r_valid), 64'd0);
    check("rst_b_valid", 64'(bus.b_valid), 64'd0);
    check("rst_r_last", 64'(bus.r_last), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] addr;
    int n;
    for (int i = 0; i < WORDS; i++) begin ref_mem[i] = '0; ref_kn[i] = '0; end
    bus.ar_valid = 0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = 3'd3; bus.ar_burst = 2'd1; bus.ar_id = '0;
    bus.aw_valid = 0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = 3'd3; bus.aw_burst = 2'd1; bus.aw_id = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0;
    bus.r_ready = 0; bus.b_ready = 0;

    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_outputs();
    aresetn = 1'b1;
    @(negedge aclk);

    for (int k = 0; k < 4; k++) begin wdata[k] = 64'h11 * 64'(k + 1); wstrb[k] = 8'hFF; end
    wr_burst(64'h100, 8'd3, 2'd1, 3'd3, 2'd2, 3, 1'b0);
    rd_burst(64'h100, 8'd3, 2'd1, 3'd3, 2'd3, 0);

    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb[0] = 8'hFF;
    wr_burst(64'h0, 8'd0, 2'd1, 3'd3, 2'd0, 0, 1'b0);
    wdata[0] = 64'h0; wstrb[0] = 8'h0F;
    wr_burst(64'h0, 8'd0, 2'd1, 3'd3, 2'd1, 0, 1'b0);
    check("strb_model", ref_mem[0], 64'hFFFF_FFFF_0000_0000);
    rd_burst(64'h0, 8'd0, 2'd1, 3'd3, 2'd1, 0);

    wdata[0] = 64'hCAFE_F00D_1234_5678; wstrb[0] = 8'hFF;
    wr_burst(64'(MEMB - 8), 8'd0, 2'd1, 3'd3, 2'd0, 0, 1'b0);
    rd_burst(64'(MEMB - 8), 8'd1, 2'd1, 3'd3, 2'd2, 0);
    fill_rand(2, 1'b1);
    wr_burst(64'(MEMB - 8), 8'd1, 2'd1, 3'd3, 2'd3, 1, 1'b0);
    rd_burst(64'(MEMB - 8), 8'd0, 2'd1, 3'd3, 2'd0, 0);

    fill_rand(8, 1'b1);
    wr_burst(64'h400, 8'd7, 2'd1, 3'd3, 2'd1, 7, 1'b0);
    rd_burst(64'h400, 8'd7, 2'd1, 3'd3, 2'd2, 2);

    wdata[0] = 64'hA; wstrb[0] = 8'hFF;
    wr_burst(64'h200, 8'd0, 2'd1, 3'd3, 2'd0, 0, 1'b0);
    wdata[0] = 64'hB;
    fork
      rd_burst(64'h200, 8'd0, 2'd1, 3'd3, 2'd1, 0);
      wr_burst(64'h200, 8'd0, 2'd1, 3'd3, 2'd2, 0, 1'b0);
    join
    check("concurrent_model", ref_mem[64'h200 >> 3], 64'hB);
    rd_burst(64'h200, 8'd0, 2'd1, 3'd3, 2'd1, 0);

    fill_rand(4, 1'b1);
    bus.aw_addr = 64'h300; bus.aw_len = 8'd3; bus.aw_burst = 2'd1; bus.aw_size = 3'd3; bus.aw_id = 2'd1;
    bus.aw_valid = 1'b1;
    n = 0;
    while (!bus.aw_ready && n < 200) begin @(negedge aclk); n++; end
    check("rst_aw_accept", 64'(bus.aw_ready), 64'd1);
    @(negedge aclk);
    bus.aw_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.w_data = wdata[k]; bus.w_strb = 8'hFF; bus.w_last = 1'b0; bus.w_valid = 1'b1;
      n = 0;
      while (!bus.w_ready && n < 200) begin @(negedge aclk); n++; end
      check("rst_w_ready", 64'(bus.w_ready), 64'd1);
      @(negedge aclk);
      bus.w_valid = 1'b0;
      ref_mem[(64'h300 >> 3) + k] = wdata[k];
      ref_kn[(64'h300 >> 3) + k] = 8'hFF;
    end
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check_reset_outputs();
    aresetn = 1'b1;
    @(negedge aclk);
    rd_burst(64'h300, 8'd1, 2'd1, 3'd3, 2'd0, 1);
    fill_rand(4, 1'b1);
    wr_burst(64'h300, 8'd3, 2'd1, 3'd3, 2'd3, 3, 1'b1);
    rd_burst(64'h300, 8'd3, 2'd1, 3'd3, 2'd3, 0);

    fill_rand(256, 1'b1);
    wr_burst(64'h1000, 8'd255, 2'd1, 3'd3, 2'd1, 255, 1'b0);
    rd_burst(64'h1000, 8'd255, 2'd1, 3'd3, 2'd1, 1);

    fill_rand(4, 1'b0);
    wr_burst(64'h800, 8'd3, 2'd0, 3'd3, 2'd2, 3, 1'b1);
    rd_burst(64'h800, 8'd3, 2'd0, 3'd3, 2'd2, 1);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] len;
      logic [1:0] burst;
      logic [2:0] size;
      if ($urandom_range(0, 7) == 0) addr = 64'(MEMB - 8 * int'($urandom_range(1, 4)));
      else addr = 64'($urandom_range(0, 127) * 8 + $urandom_range(0, 7));
      len   = 8'($urandom_range(0, 15));
      burst = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3;
      if ($urandom_range(0, 1) == 1) begin
        fill_rand(int'(len) + 1, 1'($urandom_range(0, 1)));
        wr_burst(addr, len, burst, size, 2'($urandom_range(0, 3)), int'(len), 1'b1);
      end else begin
        rd_burst(addr, len, burst, size, 2'($urandom_range(0, 3)), 1);
      end
    end

`ifdef NASTI_RAM_SLAVE_PROTO_CHK_EN
    check("proto_clean", 64'(proto_err), 64'd0);
    fill_rand(4, 1'b1);
    wr_burst(64'h500, 8'd3, 2'd1, 3'd3, 2'd1, 1, 1'b0);
    check("proto_set", 64'(proto_err), 64'd1);
    repeat (3) @(negedge aclk);
    check("proto_sticky", 64'(proto_err), 64'd1);
    rd_burst(64'h500, 8'd3, 2'd1, 3'd3, 2'd1, 0);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("proto_cleared", 64'(proto_err), 64'd0);
`else
    check("proto_tied", 64'(proto_err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nasti_ram_slave.md
Name: nasti_ram_slave

Overview:
- NASTI responder (slave) fronting an internal word-addressed RAM; the target end of the NASTI burst traffic issued by the team's DMA/data-mover masters.
- Independent read and write engines, so AR/R and AW/W/B progress concurrently.
- Supports INCR and FIXED bursts up to 256 beats, byte strobes, and per-burst SLVERR reporting.
- Used as scratchpad/boot RAM and as the standard bench target for masters.

Parameters:
- ADDR_WIDTH, 64, NASTI address width.
- DATA_WIDTH, 64, NASTI data width; power of two, 32..512.
- ID_WIDTH, 1, NASTI ID width.
- MEM_BYTES, 65536, RAM size in bytes; multiple of DATA_WIDTH/8; base address 0.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset, synchronous, active-low.
- s  nasti_channel.slave  —  NASTI slave port (AR/R/AW/W/B).
- proto_err  output  1  sticky write-protocol error flag (see Optional Feature).

Behaviour:
- Clocking/reset: one clock, aclk. aresetn is synchronous and active-low.
  - Reset values: ar_ready=0, aw_ready=0, w_ready=0, r_valid=0, b_valid=0, r_last=0, proto_err=0. Both FSMs go to IDLE.
  - Reset mid-burst abandons the burst. Writes already committed stay in RAM; RAM contents are not cleared.
- Constants: SHIFT = log2(DATA_WIDTH/8). Word index = addr[ADDR_WIDTH-1:SHIFT]; low address bits are ignored (aligned bursts only).
- Read FSM, R_IDLE -> R_BURST -> R_IDLE:
  - ar_ready=1 only in R_IDLE.
  - On ar_valid&ar_ready: latch id, word index, len, burst, and err. err=1 if size!=SHIFT, or burst is neither INCR(01) nor FIXED(00), or any beat address >= MEM_BYTES.
  - r_valid rises the cycle after the AR handshake.
  - Beat k carries mem[idx+k] for INCR, or mem[idx] every beat for FIXED.
  - r_last=1 on beat len. r_id = latched id. r_resp = SLVERR(10) if err, else OKAY(00). r_data = 0 for out-of-range beats.
  - r_valid and r_data are held stable while r_ready=0. Sustained rate is one beat per cycle with r_ready high.
  - After the last-beat handshake: return to R_IDLE; ar_ready=1 the next cycle.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - aw_ready=1 only in W_IDLE. On handshake: latch id, index, len, burst, and err (same rules as read); clear the beat counter.
  - W_DATA: w_ready=1. Each w_valid&w_ready beat writes the bytes with w_strb[i]=1 into the current word, unless the beat is out of range or err is set (then the write is dropped).
  - The beat counter ends the burst: after beat len, go to W_RESP. w_last is not used for termination.
  - W_RESP: b_valid=1, b_id = latched id, b_resp = SLVERR if err, else OKAY. Hold until b_ready, then go to W_IDLE.
- Simultaneous read and write of the same word in one cycle: the read returns the old data (read-first).
- Simultaneous AR and AW handshakes are both accepted; there is no arbitration between them.
- len=0 gives a single beat, which is also the last beat.
- The beat counter is 8 bits; len=255 gives 256 beats without wrap error.
- Index arithmetic is done at ADDR_WIDTH-SHIFT bits. Range check is (idx+len)*bytes < MEM_BYTES, evaluated once per burst.

Optional Feature:
- Macro: NASTI_RAM_SLAVE_PROTO_CHK_EN.
- Defined:
  - proto_err is set and held until reset if w_last=1 on a beat other than len, or w_last=0 on beat len.
  - proto_err is also set if w_valid=1 while in W_IDLE.
  - Data handling is unchanged.
- Undefined: proto_err is tied to 0, w_last is ignored, and the checker logic is absent.

Decomposition:
- Package nasti_slave_pkg holds:
  - resp codes RESP_OKAY, RESP_SLVERR.
  - burst codes BURST_FIXED, BURST_INCR.
  - enums rd_state_t {R_IDLE, R_BURST} and wr_state_t {W_IDLE, W_DATA, W_RESP}.
- Sub-module nasti_ram_burst_addr: takes start index, len and burst; provides the current index, a last-beat flag, and the range error. Instanced once for read and once for write.

Test Plan:
- AW addr 0x100, len=3, INCR, data 0x11..0x44, full strb -> B OKAY with id echoed. Then AR addr 0x100, len=3 -> R beats 0x11, 0x22, 0x33, 0x44; r_last on the 4th beat; each beat OKAY.
- Write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then write 0x0 with strb=0x0F; read back -> 0xFFFF_FFFF_0000_0000.
- AR addr MEM_BYTES-8, len=1 -> 2 beats, both SLVERR, second beat data 0. AW at the same address -> SLVERR, and the in-range word is unmodified.
- AR len=7 with r_ready toggled 1,0,0,1,...:
  - r_data/r_valid stay stable while stalled.
  - 8 beats are delivered in order.
  - ar_ready returns exactly 1 cycle after the last handshake.
- Concurrent AR and AW to 0x200 in the same cycle; old contents 0xA, write data 0xB -> read returns 0xA; a later read returns 0xB.
- Reset mid-write burst after 2 of 4 beats -> all outputs at reset values; the 2 beats are committed; the next AW is accepted normally.
- With NASTI_RAM_SLAVE_PROTO_CHK_EN: w_last on beat 1 of len=3 -> proto_err=1 from the next cycle until reset, and B still returns after 4 beats.
